// File: rtl/top_if.sv
// Key/tone/LED bundle of the music-tone clock generator.
//   key_in        : active-low push button, asynchronous to clk
//   final_clk_out : registered tone square wave
//   led_mode0..2  : one-hot display of the latched mode
// The master modport drives the button and watches the outputs.
// The slave modport is the generator side.
interface top_if;
  logic key_in;
  logic final_clk_out;
  logic led_mode0;
  logic led_mode1;
  logic led_mode2;

  modport master (
    output key_in,
    input  final_clk_out,
    input  led_mode0,
    input  led_mode1,
    input  led_mode2
  );

  modport slave (
    input  key_in,
    output final_clk_out,
    output led_mode0,
    output led_mode1,
    output led_mode2
  );
endinterface

// File: rtl/top.sv
// Music-tone clock generator.
// A 100 MHz clock is divided down to a square-wave tone.
// One push button steps through three pitches, and a one-hot LED
// shows which pitch is active.
//   clk   : 100 MHz system clock; all state changes on its rising edge
//   rst_n : asynchronous reset, active-high despite the name
//   bus   : top_if slave (key_in, final_clk_out, led_mode0..2)
// The divider stages run from clock enables in the single clk domain.
module top (
  input  logic clk,
  input  logic rst_n,
  top_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_X = 2'd3
  } mode_t;

  logic       s1, s2, s3;
  logic       press;
  mode_t      mode, mode_next;
  logic [1:0] cnt_a;
  logic [8:0] cnt_sw;
  logic       ce_a, ce_sw, ce_b;
  logic [7:0] m_preset;
  logic [4:0] p_preset;
  logic [2:0] leds;
  logic [7:0] ca;
  logic       a, a_d;
  logic [4:0] cb;
  logic       tone;

  // Three-stage sampler on the button.
  // The first stage absorbs metastability.
  // A press is a 1 seen in s3 followed by a 0 in s2.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus.key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s3 & ~s2;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) mode <= MODE_0;
    else       mode <= mode_next;
  end

  // The illegal encoding falls back to mode 0 on the next press.
  always_comb begin
    mode_next = mode;
    if (press) begin
      case (mode)
        MODE_0:  mode_next = MODE_1;
        MODE_1:  mode_next = MODE_2;
        default: mode_next = MODE_0;
      endcase
    end
  end

  // Free-running enable counters.
  // ce_a fires on edges 2, 6, 10, ...
  // ce_sw fires on edge 250 after reset, then every 500 edges.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_a  <= 2'd0;
      cnt_sw <= 9'd0;
    end else begin
      cnt_a  <= cnt_a + 2'd1;
      cnt_sw <= (cnt_sw == 9'd499) ? 9'd0 : cnt_sw + 9'd1;
    end
  end

  assign ce_a  = (cnt_a == 2'd1);
  assign ce_sw = (cnt_sw == 9'd249);

  // Presets and LEDs only follow the mode register at ce_sw.
  // A press therefore changes pitch only at the next switch slot.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_preset <= 8'd0;
      p_preset <= 5'd0;
      leds     <= 3'b000;
    end else if (ce_sw) begin
      case (mode)
        MODE_1: begin
          m_preset <= 8'd49;
          p_preset <= 5'd9;
          leds     <= 3'b010;
        end
        MODE_2: begin
          m_preset <= 8'd99;
          p_preset <= 5'd19;
          leds     <= 3'b100;
        end
        default: begin
          m_preset <= 8'd24;
          p_preset <= 5'd4;
          leds     <= 3'b001;
        end
      endcase
    end
  end

  // Stage A divides the ce_a rate by 2(M+1).
  // The >= compare lets a smaller new preset wrap at once
  // instead of running the counter all the way round.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ca  <= 8'd0;
      a   <= 1'b0;
      a_d <= 1'b0;
    end else begin
      a_d <= a;
      if (ce_a) begin
        if (ca >= m_preset) begin
          ca <= 8'd0;
          a  <= ~a;
        end else begin
          ca <= ca + 8'd1;
        end
      end
    end
  end

  assign ce_b = a & ~a_d;

  // Stage B divides the rising edges of a by 2(P+1) and drives the tone.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cb   <= 5'd0;
      tone <= 1'b0;
    end else if (ce_b) begin
      if (cb >= p_preset) begin
        cb   <= 5'd0;
        tone <= ~tone;
      end else begin
        cb <= cb + 5'd1;
      end
    end
  end

  assign bus.final_clk_out = tone;
  assign bus.led_mode0     = leds[0];
  assign bus.led_mode1     = leds[1];
  assign bus.led_mode2     = leds[2];

endmodule

// File: tb/tb_top.sv
// Bench for the music-tone clock generator.
// Drives button presses of several widths and resets, and tracks the
// expected tone and LEDs with an edge-indexed model of the divider rules.
module tb_top;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  top_if bus ();

  top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int PRESET_M [3] = '{24, 49, 99};
  localparam int PRESET_P [3] = '{4, 9, 19};

  int         m_edge;
  int         m_mode;
  int         m_m, m_p, m_ca, m_cb;
  logic [2:0] m_leds;
  bit         m_a, m_tone, m_b_pending;
  bit   [2:0] key_hist;

  task automatic model_reset();
    m_edge      = 0;
    m_mode      = 0;
    m_m         = 0;
    m_p         = 0;
    m_ca        = 0;
    m_cb        = 0;
    m_leds      = 3'b000;
    m_a         = 1'b0;
    m_tone      = 1'b0;
    m_b_pending = 1'b0;
    key_hist    = 3'b111;
  endtask

  // Edge-indexed model.
  // m_edge counts rising edges since reset release, starting at 1.
  // key_hist holds key samples from edges n-1, n-2 and n-3.
  always @(posedge clk or posedge rst_n) begin
    bit strobe, ce_a, ce_sw, do_b;
    int old_m, old_p;
    if (rst_n) begin
      model_reset();
    end else begin
      m_edge      = m_edge + 1;
      strobe      = key_hist[2] && !key_hist[1];
      ce_a        = (m_edge % 4) == 2;
      ce_sw       = (m_edge % 500) == 250;
      old_m       = m_m;
      old_p       = m_p;
      do_b        = m_b_pending;
      m_b_pending = 1'b0;
      if (ce_sw) begin
        m_m    = PRESET_M[m_mode];
        m_p    = PRESET_P[m_mode];
        m_leds = 3'(1 << m_mode);
      end
      if (strobe) m_mode = (m_mode + 1) % 3;
      if (ce_a) begin
        if (m_ca >= old_m) begin
          m_ca = 0;
          m_a  = !m_a;
          if (m_a) m_b_pending = 1'b1;
        end else begin
          m_ca = m_ca + 1;
        end
      end
      if (do_b) begin
        if (m_cb >= old_p) begin
          m_cb   = 0;
          m_tone = !m_tone;
        end else begin
          m_cb = m_cb + 1;
        end
      end
      key_hist = {key_hist[1:0], bus.key_in};
    end
  end

  // Compare the DUT against the model on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      checks = checks + 1;
      if ({bus.led_mode2, bus.led_mode1, bus.led_mode0, bus.final_clk_out} !==
          {m_leds, m_tone}) begin
        fails = fails + 1;
        $display("[TB] FAIL model_cmp edge %0d: got leds=%b tone=%b expected leds=%b tone=%b",
                 m_edge, {bus.led_mode2, bus.led_mode1, bus.led_mode0},
                 bus.final_clk_out, m_leds, m_tone);
      end
    end
  end

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Press the button: low for low_cycles full clock periods.
  task automatic apply_stimulus(int low_cycles);
    @(negedge clk);
    bus.key_in = 1'b0;
    repeat (low_cycles) @(negedge clk);
    bus.key_in = 1'b1;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] dut_leds();
    return {bus.led_mode2, bus.led_mode1, bus.led_mode0};
  endfunction

  task automatic wait_leds(logic [2:0] expected, int budget, string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut_leds() === expected) break;
    end
    check_output(name, 32'(dut_leds()), 32'(expected));
  endtask

  task automatic wait_out(logic level, int budget, string name, output longint t);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.final_clk_out === level) break;
    end
    t = $time;
    check_output(name, 32'(i < budget), 32'd1);
  endtask

  // Called right after reset release at a falling edge (edge 0).
  task automatic fresh_start_checks(string tag);
    wait_cycles(2);
    check_output({tag, "_tone_e2"}, 32'(bus.final_clk_out), 32'd0);
    wait_cycles(1);
    check_output({tag, "_tone_e3"}, 32'(bus.final_clk_out), 32'd1);
    wait_cycles(8);
    check_output({tag, "_tone_e11"}, 32'(bus.final_clk_out), 32'd0);
    wait_cycles(238);
    check_output({tag, "_leds_e249"}, 32'(dut_leds()), 32'd0);
    wait_cycles(1);
    check_output({tag, "_leds_e250"}, 32'(dut_leds()), 32'b001);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint t_rise1, t_fall, t_rise2;
    logic [2:0] exp_leds;
    int tries;

    bus.key_in = 1'b1;
    rst_n      = 1'b1;
    #12;
    check_output("reset_outputs",
                 32'({dut_leds(), bus.final_clk_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    fresh_start_checks("start");

    // Mode 0: 2000-cycle period, 1000-cycle high phase.
    wait_cycles(300);
    wait_out(1'b0, 3000, "m0_low_seen", t_rise1);
    wait_out(1'b1, 3000, "m0_rise1", t_rise1);
    wait_out(1'b0, 3000, "m0_fall", t_fall);
    wait_out(1'b1, 3000, "m0_rise2", t_rise2);
    check_output("m0_high_cycles", 32'((t_fall - t_rise1) / 10), 32'd1000);
    check_output("m0_period_cycles", 32'((t_rise2 - t_rise1) / 10), 32'd2000);

    apply_stimulus(5);
    wait_leds(3'b010, 510, "press1_mode1");
    apply_stimulus(5);
    wait_leds(3'b100, 510, "press2_mode2");
    apply_stimulus(5);
    wait_leds(3'b001, 510, "press3_mode0");

    // Long hold: one advance on the press, nothing on the release.
    apply_stimulus(700);
    check_output("hold_mode1", 32'(dut_leds()), 32'b010);
    wait_cycles(600);
    check_output("release_no_advance", 32'(dut_leds()), 32'b010);

    apply_stimulus(1);
    wait_cycles(600);

    exp_leds = 3'(1 << ((m_mode + 1) % 3));
    apply_stimulus(3);
    wait_leds(exp_leds, 510, "pulse30ns_one_advance");

    tries = 0;
    while (m_mode != 2 && tries < 3) begin
      apply_stimulus(5);
      wait_cycles(10);
      tries++;
    end
    wait_leds(3'b100, 510, "pre_reset_mode2");

    // Reset in the middle of a tone period.
    wait_cycles(777);
    #3;
    rst_n = 1'b1;
    #1;
    check_output("midrun_reset_outputs",
                 32'({dut_leds(), bus.final_clk_out}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    fresh_start_checks("restart");

    // Mode 2: 16000-cycle high phase.
    apply_stimulus(5);
    wait_cycles(10);
    apply_stimulus(5);
    wait_leds(3'b100, 520, "restart_mode2");
    wait_out(1'b0, 40000, "m2_low_seen", t_rise1);
    wait_out(1'b1, 40000, "m2_rise", t_rise1);
    wait_out(1'b0, 40000, "m2_fall", t_fall);
    check_output("m2_high_cycles", 32'((t_fall - t_rise1) / 10), 32'd16000);

    wait_cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
